// File: rtl/npu_host_master.sv
// npu_host_master: byte stream to NPU host-port write/trigger/poll/read sequencer; `define NPU_HOST_PERF_EN adds a cycles counter
module npu_host_master #(
  parameter int IMG_BYTES = 240,
  parameter int WC_BYTES = 9,
  parameter int FC2_BYTES = 10,
  parameter int RD_LAT = 2,
  parameter int POLL_MAX = 4095,
  parameter logic [2:0] STATUS_SEL = 3'b110
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta,
  output logic        busy,
  output logic        done,
  output logic [23:0] result,
  output logic        err
`ifdef NPU_HOST_PERF_EN
  ,
  output logic [31:0] cycles
`endif
);
  localparam int KW = $clog2(IMG_BYTES + WC_BYTES + FC2_BYTES + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_WR = 4'd2;
  localparam logic [3:0] S_TRIG = 4'd3;
  localparam logic [3:0] S_POLL_RD = 4'd4;
  localparam logic [3:0] S_POLL_WAIT = 4'd5;
  localparam logic [3:0] S_RES_RD = 4'd6;
  localparam logic [3:0] S_RES_WAIT = 4'd7;
  localparam logic [3:0] S_FIN = 4'd8;
  logic [3:0] state;
  logic [1:0] seg;
  logic [KW-1:0] k, seg_len;
  logic [31:0] wbuf, word;
  logic [PW-1:0] pcnt;
  logic [LW-1:0] lat;
  logic [2:0] sel;
  logic word_full;
  logic unused;
  assign unused = ^douta[31:24];
  assign s_ready = state == S_LOAD;
  // segment geometry and the word being assembled from the incoming byte
  always_comb begin
    seg_len = seg == 2'd0 ? KW'(IMG_BYTES) : seg == 2'd1 ? KW'(WC_BYTES) : KW'(FC2_BYTES);
    sel = seg == 2'd0 ? 3'b001 : seg == 2'd1 ? 3'b010 : 3'b100;
    word = wbuf | (32'(s_data) << {k[1:0], 3'b000});
    word_full = k[1:0] == 2'd3 || k + KW'(1) == seg_len;
  end
  // sequencer: bus outputs are loaded on entry to the state that owns the transaction
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      seg <= 2'd0;
      k <= '0;
      wbuf <= '0;
      pcnt <= '0;
      lat <= '0;
      ena <= 1'b0;
      wea <= 1'b0;
      addra <= '0;
      dina <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      err <= 1'b0;
    end else begin
      ena <= 1'b0;
      wea <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD;
          seg <= 2'd0;
          k <= '0;
          wbuf <= '0;
          pcnt <= '0;
          busy <= 1'b1;
          err <= 1'b0;
        end
        S_LOAD: if (s_valid) begin
          k <= k + KW'(1);
          wbuf <= word_full ? '0 : word;
          if (word_full) begin
            dina <= word;
            addra <= {1'b0, sel, 12'(k >> 2)};
            ena <= 1'b1;
            wea <= 1'b1;
            state <= S_WR;
          end
        end
        S_WR: if (k != seg_len) state <= S_LOAD;
        else if (seg != 2'd2) begin
          seg <= seg + 2'd1;
          k <= '0;
          state <= S_LOAD;
        end else begin
          ena <= 1'b1;
          wea <= 1'b1;
          addra <= {1'b0, 3'b101, 12'd0};
          dina <= 32'h1;
          state <= S_TRIG;
        end
        S_TRIG: begin
          ena <= 1'b1;
          addra <= {1'b0, STATUS_SEL, 12'd0};
          state <= S_POLL_RD;
        end
        S_POLL_RD: begin
          lat <= LW'(1);
          state <= S_POLL_WAIT;
        end
        S_POLL_WAIT: if (lat != LW'(RD_LAT)) lat <= lat + LW'(1);
        else if (douta[0]) begin
          ena <= 1'b1;
          addra <= {1'b0, STATUS_SEL, 12'd4};
          state <= S_RES_RD;
        end else if (pcnt == PW'(POLL_MAX - 1)) begin
          err <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_FIN;
        end else begin
          pcnt <= pcnt + PW'(1);
          ena <= 1'b1;
          addra <= {1'b0, STATUS_SEL, 12'd0};
          state <= S_POLL_RD;
        end
        S_RES_RD: begin
          lat <= LW'(1);
          state <= S_RES_WAIT;
        end
        S_RES_WAIT: if (lat != LW'(RD_LAT)) lat <= lat + LW'(1);
        else begin
          result <= douta[23:0];
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef NPU_HOST_PERF_EN
  // run length: the accepted start cycle counts as 1, then every cycle up to and including FIN
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cycles <= '0;
    else if (state == S_IDLE) cycles <= start ? 32'd1 : cycles;
    else cycles <= cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_npu_host_master.sv
// tb_npu_host_master: randomized stream runs against a transaction-level model of the host-port sequence
module tb_npu_host_master;
  localparam int NB = 259;
  localparam int RD_LAT = 2;
  typedef struct {
    int gap;
    int nd;
    bit b;
    bit fixed;
    logic [23:0] rv;
    bit e_err;
    logic [23:0] e_res;
  } vec_t;
  logic clk = 1'b0, rst_ni = 1'b0, start_a = 1'b0, start_b = 1'b0, s_valid = 1'b0, use_b = 1'b0;
  logic [7:0] s_data = 8'h0;
  logic [31:0] douta;
  logic s_ready_a, ena_a, wea_a, busy_a, done_a, err_a;
  logic s_ready_b, ena_b, wea_b, busy_b, done_b, err_b;
  logic [15:0] addra_a, addra_b;
  logic [31:0] dina_a, dina_b;
  logic [23:0] result_a, result_b;
  logic m_s_ready, m_ena, m_wea, m_busy, m_done, m_err;
  logic [15:0] m_addra;
  logic [31:0] m_dina;
  logic [23:0] m_result;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
`ifdef NPU_HOST_PERF_EN
  logic [31:0] cycles_a, cycles_b, m_cycles;
  assign m_cycles = use_b ? cycles_b : cycles_a;
`endif
  npu_host_master dut_a (
    .clk(clk), .rst_ni(rst_ni), .start(start_a), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a), .douta(douta),
    .busy(busy_a), .done(done_a), .result(result_a), .err(err_a)
`ifdef NPU_HOST_PERF_EN
    , .cycles(cycles_a)
`endif
  );
  npu_host_master #(.POLL_MAX(4)) dut_b (
    .clk(clk), .rst_ni(rst_ni), .start(start_b), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta),
    .busy(busy_b), .done(done_b), .result(result_b), .err(err_b)
`ifdef NPU_HOST_PERF_EN
    , .cycles(cycles_b)
`endif
  );
  assign m_s_ready = use_b ? s_ready_b : s_ready_a;
  assign m_ena = use_b ? ena_b : ena_a;
  assign m_wea = use_b ? wea_b : wea_a;
  assign m_addra = use_b ? addra_b : addra_a;
  assign m_dina = use_b ? dina_b : dina_a;
  assign m_busy = use_b ? busy_b : busy_a;
  assign m_done = use_b ? done_b : done_a;
  assign m_err = use_b ? err_b : err_a;
  assign m_result = use_b ? result_b : result_a;
  // NPU stub: status reports done once more than nd polls were seen; data appears RD_LAT cycles after the request
  int notdone_n = 0, sreads = 0;
  logic [23:0] resval = 24'h0;
  logic [31:0] pipe0 = 32'h0, pipe1 = 32'h0;
  always @(posedge clk) begin
    if ((start_a && !busy_a) || (start_b && !busy_b)) sreads = 0;
    pipe1 <= pipe0;
    pipe0 <= 32'h0;
    if (m_ena && !m_wea) begin
      if (m_addra == 16'h6000) begin
        sreads = sreads + 1;
        pipe0 <= {31'b0, sreads > notdone_n};
      end else pipe0 <= {8'hA5, resval};
    end
  end
  assign douta = pipe1;
  // bus monitor: records transactions and protocol violations (wea without ena, bus drift while idle)
  logic [47:0] wq[$];
  logic [15:0] rq[$];
  int done_cnt = 0, viol = 0;
  logic [47:0] last_bus = 48'h0;
  logic prev_rst = 1'b0, prev_use = 1'b0;
  always @(negedge clk) begin
    if (m_ena && m_wea) wq.push_back({m_addra, m_dina});
    if (m_ena && !m_wea) rq.push_back(m_addra);
    if (m_done) done_cnt++;
    if (m_wea && !m_ena) viol++;
    if (rst_ni && prev_rst && use_b == prev_use && !m_ena && {m_addra, m_dina} != last_bus) viol++;
    last_bus = {m_addra, m_dina};
    prev_rst = rst_ni;
    prev_use = use_b;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    logic [7:0] bv[NB];
    logic [47:0] exp_w[$];
    logic [15:0] exp_r[$];
    int idx, cyc, off, pm, nst;
    bit acc, poked, e_err_m;
    int lens[3] = '{240, 9, 10};
    logic [2:0] sels[3] = '{3'b001, 3'b010, 3'b100};
    for (int i = 0; i < NB; i++)
      bv[i] = v.fixed ? (i < 240 ? 8'(i) : i < 249 ? 8'(i - 239) : 8'(i - 249 + 8'hF6)) : 8'($urandom_range(255));
    off = 0;
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < (lens[s] + 3) / 4; w++) begin
        logic [31:0] d = 32'h0;
        for (int j = 0; j < 4; j++)
          if (4 * w + j < lens[s]) d = d | (32'(bv[off + 4 * w + j]) << (8 * j));
        exp_w.push_back({1'b0, sels[s], 12'(w), d});
      end
      off += lens[s];
    end
    exp_w.push_back({16'h5000, 32'h1});
    pm = v.b ? 4 : 4095;
    e_err_m = v.nd >= pm;
    nst = e_err_m ? pm : v.nd + 1;
    for (int i = 0; i < nst; i++) exp_r.push_back(16'h6000);
    if (!e_err_m) exp_r.push_back(16'h6004);
    use_b = v.b;
    notdone_n = v.nd;
    resval = v.rv;
    @(negedge clk);
    wq.delete();
    rq.delete();
    done_cnt = 0;
    start_a = !v.b;
    start_b = v.b;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    idx = 0;
    cyc = 0;
    poked = 1'b0;
    while (idx < NB && cyc < 20 * NB) begin
      s_valid = $urandom_range(99) >= v.gap;
      s_data = bv[idx];
      if (idx == 100 && !poked) begin
        poked = 1'b1;
        start_a = !v.b;
        start_b = v.b;
      end
      acc = s_valid && m_s_ready;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    chk("stream_consumed", 64'(idx), 64'(NB));
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (4) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("busy_after", 64'(m_busy), 64'd0);
    chk("err", 64'(m_err), 64'(v.e_err));
    chk("result", 64'(m_result), 64'(v.e_res));
    chk("write_count", 64'(wq.size()), 64'(exp_w.size()));
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) chk($sformatf("write%0d", i), 64'(wq[i]), 64'(exp_w[i]));
    chk("read_count", 64'(rq.size()), 64'(exp_r.size()));
    for (int i = 0; i < rq.size() && i < exp_r.size(); i++) chk($sformatf("read%0d", i), 64'(rq[i]), 64'(exp_r[i]));
    chk("protocol", 64'(viol), 64'd0);
    if (v.fixed && wq.size() >= 67) begin
      chk("wr0_fixed", 64'(wq[0]), {16'h0, 16'h1000, 32'h03020100});
      chk("wr59_fixed", 64'(wq[59]), {16'h0, 16'h103B, 32'hEFEEEDEC});
      chk("wc2_fixed", 64'(wq[62]), {16'h0, 16'h2002, 32'h00000009});
      chk("trig_fixed", 64'(wq[66]), {16'h0, 16'h5000, 32'h00000001});
    end
`ifdef NPU_HOST_PERF_EN
    if (v.gap == 0) chk("cycles", 64'(m_cycles), 64'(1 + NB + exp_w.size() - 1 + 1 + (1 + RD_LAT) * nst + (e_err_m ? 0 : 1 + RD_LAT) + 1));
`endif
  endtask
  vec_t tbl[6];
  initial begin
    int idx, cyc;
    bit acc;
    tbl[0] = '{gap: 0, nd: 5, b: 1'b0, fixed: 1'b1, rv: 24'hFFFF85, e_err: 1'b0, e_res: 24'hFFFF85};
    tbl[1] = '{gap: 50, nd: 5, b: 1'b0, fixed: 1'b0, rv: 24'h000123, e_err: 1'b0, e_res: 24'h000123};
    tbl[2] = '{gap: 0, nd: 0, b: 1'b0, fixed: 1'b0, rv: 24'h7FFFFF, e_err: 1'b0, e_res: 24'h7FFFFF};
    tbl[3] = '{gap: 0, nd: 1, b: 1'b1, fixed: 1'b0, rv: 24'h800000, e_err: 1'b0, e_res: 24'h800000};
    tbl[4] = '{gap: 30, nd: 1000000, b: 1'b1, fixed: 1'b0, rv: 24'h111111, e_err: 1'b1, e_res: 24'h800000};
    tbl[5] = '{gap: 50, nd: 5, b: 1'b0, fixed: 1'b1, rv: 24'hFFFF85, e_err: 1'b0, e_res: 24'hFFFF85};
    repeat (2) @(negedge clk);
    chk("reset_a", {s_ready_a, ena_a, wea_a, busy_a, done_a, err_a, addra_a, dina_a}, 64'h0);
    chk("reset_a_result", 64'(result_a), 64'h0);
    chk("reset_b", {s_ready_b, ena_b, wea_b, busy_b, done_b, err_b, addra_b, dina_b}, 64'h0);
    rst_ni = 1'b1;
    for (int t = 0; t < 6; t++) run(tbl[t]);
    use_b = 1'b0;
    @(negedge clk);
    wq.delete();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    idx = 0;
    cyc = 0;
    s_valid = 1'b1;
    while (wq.size() < 31 && cyc < 1000) begin
      s_data = 8'(idx);
      acc = m_s_ready;
      @(negedge clk);
      #1;
      cyc++;
      if (acc) idx++;
    end
    chk("abort_reached_wr30", 64'(wq.size()), 64'd31);
    rst_ni = 1'b0;
    #1;
    chk("abort_outputs", {s_ready_a, ena_a, wea_a, busy_a, done_a, err_a, addra_a, dina_a}, 64'h0);
    chk("abort_result", 64'(result_a), 64'h0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    run(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
